// File: rtl/pipe_hazard_if.sv
// rtl/pipe_hazard_if.sv - datapath <-> hazard controller signal bundle
// master: datapath side (drives hazard inputs); slave: pipe_hazard_ctrl.
interface pipe_hazard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             start;
    logic             imem_rdy;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_halt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic             mem_br_taken;

    logic             pc_we;
    logic             pc_sel_br;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [3:0]       stage_vld;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output start, imem_rdy, id_rs, id_rt, id_uses_rt, id_halt,
               ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_br_taken,
        input  pc_we, pc_sel_br, ifid_we, ifid_flush, idex_flush, exmem_flush,
               stage_vld, halted, stall_cnt
    );

    modport slave (
        input  start, imem_rdy, id_rs, id_rt, id_uses_rt, id_halt,
               ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_br_taken,
        output pc_we, pc_sel_br, ifid_we, ifid_flush, idex_flush, exmem_flush,
               stage_vld, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline sequencing and hazard controller
// Optional macro FORWARD_EN: datapath forwards from EX/MEM, so only load-use stalls.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    pipe_hazard_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_vld;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_hit_rs;
    logic w_ex_hit_rt;
    logic w_mem_hit_rs;
    logic w_mem_hit_rt;
    logic w_match_rs;
    logic w_match_rt;
    logic w_run;
    logic w_drain;
    logic w_hz;
    logic w_br;
    logic w_stall;
    logic w_halt;
    logic w_adv;

    logic       w_pc_we;
    logic       w_pc_sel_br;
    logic       w_ifid_we;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic       w_exmem_flush;
    logic [3:0] w_vld_nxt;

`ifdef FORWARD_EN
    // Only a load in EX cannot be forwarded in time; MEM results always forward.
    assign w_ex_hit_rs  = bus.ex_regwrite && bus.ex_memread && (bus.id_rs == bus.ex_rd);
    assign w_ex_hit_rt  = bus.ex_regwrite && bus.ex_memread && (bus.id_rt == bus.ex_rd);
    assign w_mem_hit_rs = 1'b0;
    assign w_mem_hit_rt = 1'b0;

    logic w_unused_mem;
    assign w_unused_mem = ^{bus.mem_rd, bus.mem_regwrite};
`else
    assign w_ex_hit_rs  = bus.ex_regwrite  && (bus.id_rs == bus.ex_rd);
    assign w_ex_hit_rt  = bus.ex_regwrite  && (bus.id_rt == bus.ex_rd);
    assign w_mem_hit_rs = bus.mem_regwrite && (bus.id_rs == bus.mem_rd);
    assign w_mem_hit_rt = bus.mem_regwrite && (bus.id_rt == bus.mem_rd);
`endif

    // Register 0 is hardwired to zero, so it never carries a dependency.
    assign w_match_rs = (bus.id_rs != '0) && (w_ex_hit_rs || w_mem_hit_rs);
    assign w_match_rt = bus.id_uses_rt && (bus.id_rt != '0) && (w_ex_hit_rt || w_mem_hit_rt);

    assign w_run   = (r_state == S_RUN);
    assign w_drain = (r_state == S_DRAIN);
    assign w_hz    = r_vld[0] && (w_match_rs || w_match_rt);
    assign w_br    = (w_run || w_drain) && bus.mem_br_taken && r_vld[2];
    assign w_stall = w_run && !w_br && w_hz;
    assign w_halt  = w_run && !w_br && !w_hz && bus.id_halt && r_vld[0];
    assign w_adv   = w_run && !w_br && !w_hz && !w_halt;

    always_comb begin
        w_pc_we       = 1'b0;
        w_pc_sel_br   = 1'b0;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        if (w_br) begin
            w_pc_we       = 1'b1;
            w_pc_sel_br   = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
        end else if (w_stall) begin
            w_idex_flush = 1'b1;
        end else if (w_halt) begin
            w_ifid_flush = 1'b1;
        end else if (w_adv) begin
            w_pc_we   = bus.imem_rdy;
            w_ifid_we = bus.imem_rdy;
        end
    end

    // Valid-bit advance; the branch instruction itself still retires into MEM/WB.
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_br) begin
            w_vld_nxt = {r_vld[2], 3'b000};
        end else if (w_stall) begin
            w_vld_nxt = {r_vld[2], r_vld[1], 1'b0, r_vld[0]};
        end else if (w_halt) begin
            w_vld_nxt = {r_vld[2], r_vld[1], 2'b10};
        end else if (w_adv) begin
            w_vld_nxt = {r_vld[2:0], bus.imem_rdy};
        end else if (w_drain) begin
            w_vld_nxt = {r_vld[2], r_vld[1], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vld       <= 4'b0000;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        r_state     <= S_RUN;
                        r_halted    <= 1'b0;
                        r_stall_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_halt) begin
                        r_state <= S_DRAIN;
                    end
                    if (w_stall && (r_stall_cnt != '1)) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // An older taken branch squashes the halt and resumes fetch.
                    if (w_br) begin
                        r_state <= S_RUN;
                    end else if (w_vld_nxt[3:1] == 3'b000) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.pc_sel_br   = w_pc_sel_br;
    assign bus.ifid_we     = w_ifid_we;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.stage_vld   = r_vld;
    assign bus.halted      = r_halted;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule
